stream_reduce_engine: RTL and testbench
=======================================

Name: stream_reduce_engine

Overview:
- Parametrised successor to the single-purpose stream-sum user logic: a command-driven stream engine between an input stream FIFO, an output stream FIFO, and a bidirectional control channel.
- Each command selects an operation mode and a word count.
  - The engine consumes that many input words and emits one output word per input word.
  - It returns the reduction result on the response channel.
- Sits inside a user-logic wrapper that instantiates the stream and channel primitives; all FIFO ports here are generic, with 1-cycle read latency.

Parameters:
- W_D, 32, data word width of all streams and the channel.
- W_LEN, 16, width of the command length field; max count is 2^W_LEN-1.
- W_ACC, 32, accumulator width for SUM and PREFIX; must satisfy W_D <= W_ACC.
- SIGNED, 0, 1 means MAX/MIN compare two's-complement, 0 means unsigned.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-low reset
- in_q  in  W_D  input stream data, valid the cycle after in_deq
- in_deq  out  1  input stream dequeue
- in_empty  in  1  input stream empty
- out_d  out  W_D  output stream data
- out_enq  out  1  output stream enqueue
- out_full  in  1  output stream full
- cmd_q  in  W_D  command word, valid the cycle after cmd_deq
- cmd_deq  out  1  command dequeue
- cmd_empty  in  1  command channel empty
- rsp_d  out  W_D  response word
- rsp_enq  out  1  response enqueue
- rsp_full  in  1  response channel full
- busy  out  1  high in any state other than IDLE
- cmd_done  out  16  count of completed commands, wraps modulo 2^16

Behaviour:
- Reset (RST low at a clock edge):
  - Outputs: in_deq, out_enq, cmd_deq, rsp_enq, busy all 0; cmd_done 0.
  - Internals: skid buffer emptied, counters cleared, state IDLE.
  - Reset mid-command abandons the command; an in-flight dequeued word is discarded.
- Command format:
  - cmd_q[1:0] is the mode: 0 SUM, 1 MAX, 2 MIN, 3 PREFIX.
  - cmd_q[W_LEN+1:2] is LEN.
  - Other bits are ignored.
- States:
  - IDLE: when !cmd_empty, pulse cmd_deq for 1 cycle and go to CMD.
  - CMD: latch mode and LEN from cmd_q. Initialise acc: SUM/PREFIX to 0; MAX to the minimum representable value; MIN to the maximum representable value (both per SIGNED). Clear issued and retired counters. LEN==0 goes to RESP, otherwise RUN.
  - RUN:
    - in_deq = !in_empty && issued<LEN && (skid_occ + d_deq - out_enq) <= 1. d_deq is in_deq delayed one cycle.
    - in_deq is combinational in the registered state.
    - Word arriving (d_deq high): update acc. SUM/PREFIX add, wrapping modulo 2^W_ACC; the input is sign-extended if SIGNED, else zero-extended. MAX/MIN select per SIGNED.
    - Push the output word into the 2-entry skid buffer: PREFIX pushes the updated acc[W_D-1:0]; other modes push in_q unchanged.
    - out_enq = skid nonempty && !out_full; data is the oldest entry.
    - Push and pop in the same cycle are legal.
    - Sustains 1 word/cycle while neither in_empty nor out_full is asserted.
    - When retired==LEN (every word enqueued to the output), go to RESP.
  - RESP: when !rsp_full, pulse rsp_enq with rsp_d = acc[W_D-1:0]. MAX/MIN results fit in W_D. LEN==0 returns the initial acc. Increment cmd_done, go to IDLE.
- Boundaries:
  - in_empty stalls issue only; out_full stalls drain and, via the occupancy rule, issue.
  - The skid buffer never overflows; this is an assertion.
  - Commands are never pipelined: the next cmd_deq comes at earliest the cycle after rsp_enq.
  - No stream activity occurs outside RUN.

Decomposition:
- Shared package holds:
  - mode encodings MODE_SUM/MAX/MIN/PREFIX;
  - the command field bit positions;
  - the state encoding.
- One natural sub-module, stream_skid_buf2: a 2-entry FIFO with occupancy output, used for the output path.

Test Plan:
- SUM, LEN=4, inputs 1,2,3,4, no stalls -> out stream 1,2,3,4 back-to-back; rsp 10; cmd_done 1.
- PREFIX, LEN=5, inputs 1,1,1,1,1, out_full toggling every other cycle -> out stream 1,2,3,4,5 in order with no loss or duplication; rsp 5.
- MAX, SIGNED=1, LEN=3, inputs 0xFFFFFFFE, 0x00000003, 0x80000000 -> rsp 3. The same inputs with SIGNED=0 -> rsp 0xFFFFFFFE.
- MIN, LEN=0 -> no in_deq/out_enq; rsp 0xFFFFFFFF when unsigned; cmd_done increments.
- SUM with W_ACC=32, inputs 0xFFFFFFFF, 2 -> rsp 1 (wrap). rsp_full held 10 cycles -> rsp_enq waits, busy stays 1.
- RST low mid-RUN after 2 of 8 words -> all outputs 0 the next cycle. A fresh SUM LEN=2 with inputs 5,6 then gives rsp 11 and cmd_done 1.

Source files
------------

// File: rtl/stream_reduce_engine_pkg.sv
// Shared encodings for the stream reduce engine: modes, FSM states and
// command word field positions.
package stream_reduce_engine_pkg;

  typedef enum logic [1:0] {
    MODE_SUM    = 2'd0,
    MODE_MAX    = 2'd1,
    MODE_MIN    = 2'd2,
    MODE_PREFIX = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int unsigned CMD_MODE_LSB = 0;
  localparam int unsigned CMD_MODE_W   = 2;
  localparam int unsigned CMD_LEN_LSB  = 2;

endpackage

// File: rtl/stream_reduce_engine_skid_buf2.sv
// Two-entry FIFO with occupancy output; entry 0 is always the oldest word.
// Simultaneous push and pop are supported.
module stream_skid_buf2 #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   occ
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   occ_q, occ_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = push_data;
        else               e1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = push_data;
        end else begin
          e0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && occ_q == 2'd2));
      assert (!(pop && occ_q == 2'd0));
    end
  end

  assign pop_data = e0_q;
  assign occ      = occ_q;

endmodule

// File: rtl/stream_reduce_engine.sv
// Command-driven stream engine: per command, streams LEN words from input to
// output and returns a SUM/MAX/MIN/PREFIX reduction on the response channel.
module stream_reduce_engine
  import stream_reduce_engine_pkg::*;
#(
  parameter int unsigned W_D    = 32,
  parameter int unsigned W_LEN  = 16,
  parameter int unsigned W_ACC  = 32,
  parameter bit          SIGNED = 1'b0
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [W_D-1:0] in_q,
  output logic           in_deq,
  input  logic           in_empty,
  output logic [W_D-1:0] out_d,
  output logic           out_enq,
  input  logic           out_full,
  input  logic [W_D-1:0] cmd_q,
  output logic           cmd_deq,
  input  logic           cmd_empty,
  output logic [W_D-1:0] rsp_d,
  output logic           rsp_enq,
  input  logic           rsp_full,
  output logic           busy,
  output logic [15:0]    cmd_done
);

  localparam logic [W_D-1:0] D_MIN = SIGNED ? {1'b1, {(W_D-1){1'b0}}} : {W_D{1'b0}};
  localparam logic [W_D-1:0] D_MAX = SIGNED ? {1'b0, {(W_D-1){1'b1}}} : {W_D{1'b1}};

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [W_LEN-1:0]   len_q, len_d;
  logic [W_LEN-1:0]   issued_q, issued_d;
  logic [W_LEN-1:0]   retired_q, retired_d;
  logic [W_ACC-1:0]   acc_q, acc_d, acc_upd, word_ext;
  logic               d_deq_q, d_deq_d;
  logic [15:0]        cmd_done_q, cmd_done_d;
  logic [1:0]         skid_occ;
  logic [2:0]         occ_proj;
  logic [W_D-1:0]     push_data;
  logic               unused_cmd_bits;

  assign unused_cmd_bits = ^cmd_q;

  function automatic logic [W_ACC-1:0] extend(input logic [W_D-1:0] v);
    if (SIGNED) return W_ACC'($signed(v));
    else        return W_ACC'(v);
  endfunction

  function automatic logic greater(input logic [W_ACC-1:0] a, input logic [W_ACC-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  function automatic logic [W_ACC-1:0] acc_init(input mode_e m);
    case (m)
      MODE_MAX: return extend(D_MIN);
      MODE_MIN: return extend(D_MAX);
      default:  return '0;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_SUM;
      len_q      <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      acc_q      <= '0;
      d_deq_q    <= 1'b0;
      cmd_done_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
      acc_q      <= acc_d;
      d_deq_q    <= d_deq_d;
      cmd_done_q <= cmd_done_d;
    end
  end

  // Occupancy projection counts the word already in flight from the input
  // FIFO, so a new dequeue is only issued when both it and that word fit.
  always_comb begin
    out_enq  = (state_q == ST_RUN) && (skid_occ != 2'd0) && !out_full;
    occ_proj = {1'b0, skid_occ} + {2'b00, d_deq_q} - {2'b00, out_enq};
    in_deq   = (state_q == ST_RUN) && !in_empty && (issued_q < len_q) && (occ_proj <= 3'd1);
    // Gated by RST so a command is never popped while the FSM is held in reset.
    cmd_deq  = RST && (state_q == ST_IDLE) && !cmd_empty;
    rsp_enq  = (state_q == ST_RESP) && !rsp_full;
    busy     = (state_q != ST_IDLE);
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    issued_d   = issued_q;
    retired_d  = retired_q;
    acc_d      = acc_q;
    cmd_done_d = cmd_done_q;
    d_deq_d    = in_deq;

    word_ext = extend(in_q);
    acc_upd  = acc_q;
    unique case (mode_q)
      MODE_SUM, MODE_PREFIX: acc_upd = acc_q + word_ext;
      MODE_MAX: if (greater(word_ext, acc_q)) acc_upd = word_ext;
      MODE_MIN: if (greater(acc_q, word_ext)) acc_upd = word_ext;
    endcase
    push_data = (mode_q == MODE_PREFIX) ? acc_upd[W_D-1:0] : in_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_deq) state_d = ST_CMD;
      end
      ST_CMD: begin
        mode_d    = mode_e'(cmd_q[CMD_MODE_LSB +: CMD_MODE_W]);
        len_d     = cmd_q[CMD_LEN_LSB +: W_LEN];
        acc_d     = acc_init(mode_d);
        issued_d  = '0;
        retired_d = '0;
        state_d   = (len_d == '0) ? ST_RESP : ST_RUN;
      end
      ST_RUN: begin
        if (in_deq)  issued_d  = issued_q + W_LEN'(1);
        if (out_enq) retired_d = retired_q + W_LEN'(1);
        if (d_deq_q) acc_d     = acc_upd;
        if (retired_q == len_q) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_enq) begin
          cmd_done_d = cmd_done_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
    endcase
  end

  stream_skid_buf2 #(.W(W_D)) u_skid (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (d_deq_q),
    .push_data (push_data),
    .pop       (out_enq),
    .pop_data  (out_d),
    .occ       (skid_occ)
  );

  assign rsp_d    = acc_q[W_D-1:0];
  assign cmd_done = cmd_done_q;

endmodule

// File: tb/tb_stream_reduce_engine.sv
// Scoreboard bench for stream_reduce_engine: an unsigned and a signed instance
// share one set of FIFO models; a negedge monitor checks every enqueue.
module tb_stream_reduce_engine;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] in_q = '0;
  logic [31:0] cmd_q = '0;
  logic        in_empty, cmd_empty, out_full;
  logic        rsp_full = 1'b0;
  logic        in_deq, out_enq, cmd_deq, rsp_enq, busy;
  logic [31:0] out_d, rsp_d;
  logic [15:0] cmd_done;

  logic        s_rsp_enq;
  logic [31:0] s_rsp_d;
  logic        unused_s_in_deq, unused_s_out_enq, unused_s_cmd_deq, unused_s_busy;
  logic [31:0] unused_s_out_d;
  logic [15:0] unused_s_cmd_done;

  always #5 CLK = ~CLK;

  stream_reduce_engine #(.W_D(32), .W_LEN(16), .W_ACC(32), .SIGNED(1'b0)) u_dut (
    .CLK(CLK), .RST(RST), .in_q(in_q), .in_deq(in_deq), .in_empty(in_empty),
    .out_d(out_d), .out_enq(out_enq), .out_full(out_full),
    .cmd_q(cmd_q), .cmd_deq(cmd_deq), .cmd_empty(cmd_empty),
    .rsp_d(rsp_d), .rsp_enq(rsp_enq), .rsp_full(rsp_full),
    .busy(busy), .cmd_done(cmd_done)
  );

  stream_reduce_engine #(.W_D(32), .W_LEN(16), .W_ACC(32), .SIGNED(1'b1)) u_dut_s (
    .CLK(CLK), .RST(RST), .in_q(in_q), .in_deq(unused_s_in_deq), .in_empty(in_empty),
    .out_d(unused_s_out_d), .out_enq(unused_s_out_enq), .out_full(out_full),
    .cmd_q(cmd_q), .cmd_deq(unused_s_cmd_deq), .cmd_empty(cmd_empty),
    .rsp_d(s_rsp_d), .rsp_enq(s_rsp_enq), .rsp_full(rsp_full),
    .busy(unused_s_busy), .cmd_done(unused_s_cmd_done)
  );

  // FIFO models with 1-cycle read latency
  logic [31:0] in_mem [0:63];
  logic [31:0] cmd_mem [0:15];
  int in_wr = 0, in_rd = 0, cmd_wr = 0, cmd_rd = 0;
  assign in_empty  = (in_rd == in_wr);
  assign cmd_empty = (cmd_rd == cmd_wr);

  always @(posedge CLK) begin
    if (in_deq) begin
      in_q  <= in_mem[in_rd % 64];
      in_rd <= in_rd + 1;
    end
    if (cmd_deq) begin
      cmd_q  <= cmd_mem[cmd_rd % 16];
      cmd_rd <= cmd_rd + 1;
    end
  end

  logic toggle_en = 1'b0;
  logic phase = 1'b0;
  always @(posedge CLK) phase <= ~phase;
  assign out_full = toggle_en & phase;

  logic [31:0] exp_out[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] exp_rsp_s[$];
  int checks = 0, failures = 0;
  int cyc = 0, n_in = 0, n_out = 0;
  int out_cyc [0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    cyc++;
    if (in_deq) n_in++;
    if (out_enq) begin
      out_cyc[n_out % 256] = cyc;
      n_out++;
      if (exp_out.size() == 0) begin
        checks++; failures++;
        $display("FAIL out_unexpected actual=0x%08h expected=none", out_d);
      end else check("out_d", out_d, exp_out.pop_front());
    end
    if (rsp_enq) begin
      if (exp_rsp.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_unexpected actual=0x%08h expected=none", rsp_d);
      end else check("rsp_d", rsp_d, exp_rsp.pop_front());
    end
    if (s_rsp_enq) begin
      if (exp_rsp_s.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_s_unexpected actual=0x%08h expected=none", s_rsp_d);
      end else check("rsp_s_d", s_rsp_d, exp_rsp_s.pop_front());
    end
  end

  task automatic push_word(input logic [31:0] w, input logic [31:0] expect_out);
    exp_out.push_back(expect_out);
    in_mem[in_wr % 64] = w;
    in_wr++;
  endtask

  task automatic push_cmd(input logic [1:0] mode, input logic [15:0] len,
                          input bit has_rsp, input logic [31:0] r_u, input logic [31:0] r_s);
    if (has_rsp) begin
      exp_rsp.push_back(r_u);
      exp_rsp_s.push_back(r_s);
    end
    cmd_mem[cmd_wr % 16] = {14'b0, len, mode};
    cmd_wr++;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while ((exp_out.size() != 0 || exp_rsp.size() != 0 || exp_rsp_s.size() != 0 || busy)
           && n < limit) begin
      @(posedge CLK); #1;
      n++;
    end
    check(name, 32'(n < limit), 32'd1);
  endtask

  task automatic wait_out(input string name, input int limit);
    int n = 0;
    while (exp_out.size() != 0 && n < limit) begin
      @(posedge CLK); #1;
      n++;
    end
    check(name, 32'(n < limit), 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_in_deq"},  32'(in_deq),  32'd0);
    check({tag, "_out_enq"}, 32'(out_enq), 32'd0);
    check({tag, "_cmd_deq"}, 32'(cmd_deq), 32'd0);
    check({tag, "_rsp_enq"}, 32'(rsp_enq), 32'd0);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_cmd_done"}, 32'(cmd_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n0, n_in0, n_out0;
    repeat (3) @(posedge CLK);
    #1;
    check_quiet("reset");
    RST = 1'b1;
    @(posedge CLK); #1;

    // SUM 1..4, no stalls
    n0 = n_out;
    for (int i = 1; i <= 4; i++) push_word(32'(i), 32'(i));
    push_cmd(2'd0, 16'd4, 1'b1, 32'd10, 32'd10);
    wait_done("sum_timeout", 200);
    check("sum_back_to_back", 32'(out_cyc[(n0 + 3) % 256] - out_cyc[n0 % 256]), 32'd3);
    check("sum_cmd_done", 32'(cmd_done), 32'd1);

    // PREFIX of five ones with out_full toggling
    toggle_en = 1'b1;
    for (int i = 1; i <= 5; i++) push_word(32'd1, 32'(i));
    push_cmd(2'd3, 16'd5, 1'b1, 32'd5, 32'd5);
    wait_done("prefix_timeout", 300);
    toggle_en = 1'b0;
    check("prefix_cmd_done", 32'(cmd_done), 32'd2);

    // MAX: unsigned vs signed compare
    push_word(32'hFFFF_FFFE, 32'hFFFF_FFFE);
    push_word(32'h0000_0003, 32'h0000_0003);
    push_word(32'h8000_0000, 32'h8000_0000);
    push_cmd(2'd1, 16'd3, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done("max_timeout", 200);
    check("max_cmd_done", 32'(cmd_done), 32'd3);

    // MIN with LEN=0: initial accumulator, no stream traffic
    n_in0  = n_in;
    n_out0 = n_out;
    push_cmd(2'd2, 16'd0, 1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    wait_done("min0_timeout", 100);
    check("min0_no_in_deq", 32'(n_in), 32'(n_in0));
    check("min0_no_out_enq", 32'(n_out), 32'(n_out0));
    check("min0_cmd_done", 32'(cmd_done), 32'd4);

    // SUM wrap with response channel held full
    rsp_full = 1'b1;
    push_word(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_word(32'h0000_0002, 32'h0000_0002);
    push_cmd(2'd0, 16'd2, 1'b1, 32'd1, 32'd1);
    wait_out("wrap_out_timeout", 200);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      check("rspfull_no_enq", 32'(rsp_enq), 32'd0);
      check("rspfull_busy", 32'(busy), 32'd1);
    end
    rsp_full = 1'b0;
    wait_done("wrap_timeout", 100);
    check("wrap_cmd_done", 32'(cmd_done), 32'd5);

    // Reset mid-RUN after 2 of 8 words
    push_word(32'd7, 32'd7);
    push_word(32'd9, 32'd9);
    push_cmd(2'd0, 16'd8, 1'b0, 32'd0, 32'd0);
    wait_out("midrun_out_timeout", 200);
    @(posedge CLK); #1;
    check("midrun_busy", 32'(busy), 32'd1);
    RST = 1'b0;
    @(posedge CLK); #1;
    check_quiet("midrun_reset");
    @(posedge CLK); #1;
    RST = 1'b1;
    in_wr = in_rd;
    @(posedge CLK); #1;

    push_word(32'd5, 32'd5);
    push_word(32'd6, 32'd6);
    push_cmd(2'd0, 16'd2, 1'b1, 32'd11, 32'd11);
    wait_done("fresh_timeout", 200);
    check("fresh_cmd_done", 32'(cmd_done), 32'd1);

    repeat (3) @(posedge CLK);
    #1;
    check("leftover_out", 32'(exp_out.size()), 32'd0);
    check("leftover_rsp", 32'(exp_rsp.size() + exp_rsp_s.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
